hazard_ctrl_unit: RTL and testbench

//  Parametrised pipeline hazard controller for the 5-stage MIPS datapath; supersedes the single-cycle load-use detector.

---
 rtl/hazard_ctrl_unit_if.sv | 40 ++++
 rtl/hazard_ctrl_unit.sv | 90 +++++++++
 tb/tb_hazard_ctrl_unit.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_unit_if.sv
// Signal bundle between the control unit / branch resolver and the hazard controller.
// The controller side drives the master modport. The hazard controller uses the slave modport.
interface hazard_ctrl_unit_if #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 16
);
  logic              branch_taken_i;
  logic              jump_i;
  logic [REG_AW-1:0] id_rs_addr_i;
  logic [REG_AW-1:0] id_rt_addr_i;
  logic              id_use_rs_i;
  logic              id_use_rt_i;
  logic [REG_AW-1:0] ex_rd_addr_i;
  logic              ex_reg_write_i;
  logic              ex_mem_read_i;
  logic [REG_AW-1:0] mem_rd_addr_i;
  logic              mem_reg_write_i;
  logic              pc_write_o;
  logic              if_id_write_o;
  logic              if_flush_o;
  logic              id_flush_o;
  logic              ex_flush_o;
  logic              stall_o;
  logic [CNT_W-1:0]  stall_cnt_o;
  logic [CNT_W-1:0]  flush_cnt_o;

  modport master (
    output branch_taken_i, jump_i, id_rs_addr_i, id_rt_addr_i, id_use_rs_i, id_use_rt_i,
           ex_rd_addr_i, ex_reg_write_i, ex_mem_read_i, mem_rd_addr_i, mem_reg_write_i,
    input  pc_write_o, if_id_write_o, if_flush_o, id_flush_o, ex_flush_o, stall_o,
           stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  branch_taken_i, jump_i, id_rs_addr_i, id_rt_addr_i, id_use_rs_i, id_use_rt_i,
           ex_rd_addr_i, ex_reg_write_i, ex_mem_read_i, mem_rd_addr_i, mem_reg_write_i,
    output pc_write_o, if_id_write_o, if_flush_o, id_flush_o, ex_flush_o, stall_o,
           stall_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller for the 5-stage MIPS datapath.
// It detects multi-cycle load-use stalls and optional RAW stalls, handles branch/jump flushes, and keeps saturating counters.
module hazard_ctrl_unit #(
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned FWD_EN   = 1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic            clk_i,
  input  logic            rst_i,
  hazard_ctrl_unit_if.slave hz
);
  localparam int unsigned REM_W = (LOAD_LAT < 2) ? 1 : $clog2(LOAD_LAT + 1);

  typedef enum logic {RUN, LSTALL} state_t;

  state_t            state;
  logic [REM_W-1:0]  rem;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  logic [REG_AW-1:0] rs, rt, ex_rd, mem_rd;
  logic              hit_ex, hit_mem, lu_haz, raw_haz;
  logic              in_lstall, jump_run, stall_req, flush_evt;

  always_comb begin
    rs      = hz.id_rs_addr_i;
    rt      = hz.id_rt_addr_i;
    ex_rd   = hz.ex_rd_addr_i;
    mem_rd  = hz.mem_rd_addr_i;
    hit_ex  = (ex_rd != '0) &&
              ((hz.id_use_rs_i && ex_rd == rs) || (hz.id_use_rt_i && ex_rd == rt));
    hit_mem = (mem_rd != '0) &&
              ((hz.id_use_rs_i && mem_rd == rs) || (hz.id_use_rt_i && mem_rd == rt));
    lu_haz  = hz.ex_mem_read_i && hz.ex_reg_write_i && hit_ex;
    raw_haz = (FWD_EN == 0) &&
              ((hz.ex_reg_write_i && hit_ex) || (hz.mem_reg_write_i && hit_mem));

    in_lstall = (state == LSTALL);
    // A jump is only honoured in RUN. During LSTALL the ID instruction is held and re-presented later.
    jump_run  = hz.jump_i && !in_lstall;
    stall_req = !hz.branch_taken_i && (in_lstall || (!hz.jump_i && (lu_haz || raw_haz)));
    flush_evt = hz.branch_taken_i || jump_run;

    hz.pc_write_o    = 1'b0;
    hz.if_id_write_o = 1'b0;
    hz.if_flush_o    = 1'b0;
    hz.id_flush_o    = 1'b0;
    hz.ex_flush_o    = 1'b0;
    hz.stall_o       = 1'b0;
    if (rst_i) begin
      hz.pc_write_o    = !stall_req;
      hz.if_id_write_o = !stall_req;
      hz.if_flush_o    = hz.branch_taken_i || jump_run;
      hz.id_flush_o    = hz.branch_taken_i || stall_req;
      hz.ex_flush_o    = hz.branch_taken_i;
      hz.stall_o       = stall_req;
    end
    hz.stall_cnt_o = stall_cnt;
    hz.flush_cnt_o = flush_cnt;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state     <= RUN;
      rem       <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_req && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_evt && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);

      if (hz.branch_taken_i) begin
        state <= RUN;
        rem   <= '0;
      end else if (in_lstall) begin
        if (rem == REM_W'(1)) begin
          state <= RUN;
          rem   <= '0;
        end else begin
          rem <= rem - REM_W'(1);
        end
      end else if (!hz.jump_i && lu_haz && LOAD_LAT > 1) begin
        // The first stall cycle is spent in RUN, so LSTALL covers the remaining LOAD_LAT-1 cycles.
        state <= LSTALL;
        rem   <= REM_W'(LOAD_LAT - 1);
      end
    end
  end
endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit with three parameterisations driven in lockstep.
// It checks hand tables, directed corner sequences and random traffic against a per-instance reference model.
module tb_hazard_ctrl_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_ctrl_unit_if #(.REG_AW(5), .CNT_W(16)) if0 ();
  hazard_ctrl_unit_if #(.REG_AW(5), .CNT_W(4))  if1 ();
  hazard_ctrl_unit_if #(.REG_AW(5), .CNT_W(16)) if2 ();

  hazard_ctrl_unit #(.REG_AW(5), .LOAD_LAT(1), .FWD_EN(1), .CNT_W(16)) u0 (.clk_i(clk), .rst_i(rst_n), .hz(if0));
  hazard_ctrl_unit #(.REG_AW(5), .LOAD_LAT(3), .FWD_EN(1), .CNT_W(4))  u1 (.clk_i(clk), .rst_i(rst_n), .hz(if1));
  hazard_ctrl_unit #(.REG_AW(5), .LOAD_LAT(2), .FWD_EN(0), .CNT_W(16)) u2 (.clk_i(clk), .rst_i(rst_n), .hz(if2));

  typedef struct packed {
    logic       br, jmp;
    logic [4:0] rs, rt;
    logic       urs, urt;
    logic [4:0] exrd;
    logic       exwr, exmr;
    logic [4:0] memrd;
    logic       memwr;
  } in_t;

  // flags packed as {pc_write, if_id_write, if_flush, id_flush, ex_flush, stall}
  typedef struct {
    in_t        in;
    logic [5:0] exp;
  } vec_t;

  localparam logic [5:0] F_NORM  = 6'b110000;
  localparam logic [5:0] F_STALL = 6'b000101;
  localparam logic [5:0] F_BR    = 6'b111110;
  localparam logic [5:0] F_JMP   = 6'b111000;

  int ll[3]  = '{1, 3, 2};
  int fwd[3] = '{1, 1, 0};
  int cw[3]  = '{16, 4, 16};

  // model state: extra stall cycles still owed, and unbounded-then-clamped counters
  int m_left[3], m_sc[3], m_fc[3];
  logic [5:0] g_fl[3];
  int g_sc[3], g_fc[3];
  int nvec = 0, nerr = 0;
  int cnt;

  function automatic in_t mk(bit br, bit jmp, logic [4:0] rs, logic [4:0] rt, bit urs, bit urt,
                             logic [4:0] exrd, bit exwr, bit exmr, logic [4:0] memrd, bit memwr);
    in_t v;
    v.br = br; v.jmp = jmp; v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt;
    v.exrd = exrd; v.exwr = exwr; v.exmr = exmr; v.memrd = memrd; v.memwr = memwr;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s got=0x%0h want=0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic apply(input in_t v);
    if0.branch_taken_i = v.br;  if1.branch_taken_i = v.br;  if2.branch_taken_i = v.br;
    if0.jump_i = v.jmp;         if1.jump_i = v.jmp;         if2.jump_i = v.jmp;
    if0.id_rs_addr_i = v.rs;    if1.id_rs_addr_i = v.rs;    if2.id_rs_addr_i = v.rs;
    if0.id_rt_addr_i = v.rt;    if1.id_rt_addr_i = v.rt;    if2.id_rt_addr_i = v.rt;
    if0.id_use_rs_i = v.urs;    if1.id_use_rs_i = v.urs;    if2.id_use_rs_i = v.urs;
    if0.id_use_rt_i = v.urt;    if1.id_use_rt_i = v.urt;    if2.id_use_rt_i = v.urt;
    if0.ex_rd_addr_i = v.exrd;  if1.ex_rd_addr_i = v.exrd;  if2.ex_rd_addr_i = v.exrd;
    if0.ex_reg_write_i = v.exwr; if1.ex_reg_write_i = v.exwr; if2.ex_reg_write_i = v.exwr;
    if0.ex_mem_read_i = v.exmr; if1.ex_mem_read_i = v.exmr; if2.ex_mem_read_i = v.exmr;
    if0.mem_rd_addr_i = v.memrd; if1.mem_rd_addr_i = v.memrd; if2.mem_rd_addr_i = v.memrd;
    if0.mem_reg_write_i = v.memwr; if1.mem_reg_write_i = v.memwr; if2.mem_reg_write_i = v.memwr;
  endtask

  task automatic sample();
    g_fl[0] = {if0.pc_write_o, if0.if_id_write_o, if0.if_flush_o, if0.id_flush_o, if0.ex_flush_o, if0.stall_o};
    g_fl[1] = {if1.pc_write_o, if1.if_id_write_o, if1.if_flush_o, if1.id_flush_o, if1.ex_flush_o, if1.stall_o};
    g_fl[2] = {if2.pc_write_o, if2.if_id_write_o, if2.if_flush_o, if2.id_flush_o, if2.ex_flush_o, if2.stall_o};
    g_sc[0] = int'(if0.stall_cnt_o); g_fc[0] = int'(if0.flush_cnt_o);
    g_sc[1] = int'(if1.stall_cnt_o); g_fc[1] = int'(if1.flush_cnt_o);
    g_sc[2] = int'(if2.stall_cnt_o); g_fc[2] = int'(if2.flush_cnt_o);
  endtask

  function automatic bit reads(in_t v, logic [4:0] r);
    return (r != 0) && ((v.urs && v.rs == r) || (v.urt && v.rt == r));
  endfunction

  function automatic bit m_lu(in_t v);
    return v.exmr && v.exwr && reads(v, v.exrd);
  endfunction

  function automatic bit m_raw(int k, in_t v);
    return (fwd[k] == 0) && ((v.exwr && reads(v, v.exrd)) || (v.memwr && reads(v, v.memrd)));
  endfunction

  function automatic logic [5:0] m_flags(int k, in_t v);
    if (v.br) return F_BR;
    if (m_left[k] > 0) return F_STALL;
    if (v.jmp) return F_JMP;
    if (m_lu(v) || m_raw(k, v)) return F_STALL;
    return F_NORM;
  endfunction

  task automatic m_commit(input int k, input in_t v);
    int top;
    top = (1 << cw[k]) - 1;
    if (v.br) begin
      m_left[k] = 0;
      m_fc[k]++;
    end else if (m_left[k] > 0) begin
      m_left[k]--;
      m_sc[k]++;
    end else if (v.jmp) begin
      m_fc[k]++;
    end else if (m_lu(v)) begin
      m_left[k] = ll[k] - 1;
      m_sc[k]++;
    end else if (m_raw(k, v)) begin
      m_sc[k]++;
    end
    if (m_sc[k] > top) m_sc[k] = top;
    if (m_fc[k] > top) m_fc[k] = top;
  endtask

  task automatic step(input in_t v);
    apply(v);
    @(negedge clk);
    sample();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("flags u%0d", k), int'(g_fl[k]), int'(m_flags(k, v)));
      chk($sformatf("stall_cnt u%0d", k), g_sc[k], m_sc[k]);
      chk($sformatf("flush_cnt u%0d", k), g_fc[k], m_fc[k]);
    end
    @(posedge clk);
    for (int k = 0; k < 3; k++) m_commit(k, v);
    #1;
  endtask

  task automatic do_reset(input in_t v);
    rst_n = 1'b0;
    apply(v);
    @(negedge clk);
    sample();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst flags u%0d", k), int'(g_fl[k]), 0);
      chk($sformatf("rst stall_cnt u%0d", k), g_sc[k], 0);
      chk($sformatf("rst flush_cnt u%0d", k), g_fc[k], 0);
      m_left[k] = 0; m_sc[k] = 0; m_fc[k] = 0;
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  vec_t tbl[10];
  in_t idle, lu8, bub8;

  initial begin
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    lu8  = mk(0, 0, 8, 1, 1, 1, 8, 1, 1, 0, 0);   // lw $8 in EX, add $9,$8,$1 in ID
    bub8 = mk(0, 0, 8, 1, 1, 1, 0, 0, 0, 8, 1);   // bubble in EX, lw $8 now in MEM

    // expectations for u0 (LOAD_LAT=1, forwarding present)
    tbl[0] = '{idle, F_NORM};
    tbl[1] = '{lu8, F_STALL};
    tbl[2] = '{bub8, F_NORM};
    tbl[3] = '{mk(0, 0, 0, 0, 1, 1, 0, 1, 1, 0, 0), F_NORM};     // lw $0, use $0
    tbl[4] = '{mk(0, 0, 8, 8, 0, 0, 8, 1, 1, 0, 0), F_NORM};     // lw $8, no source used
    tbl[5] = '{mk(0, 0, 3, 8, 0, 1, 8, 1, 1, 0, 0), F_STALL};    // hit via rt
    tbl[6] = '{mk(1, 0, 8, 1, 1, 1, 8, 1, 1, 0, 0), F_BR};       // branch beats load-use
    tbl[7] = '{mk(0, 1, 8, 1, 1, 1, 8, 1, 1, 0, 0), F_JMP};      // jump beats load-use
    tbl[8] = '{mk(0, 0, 8, 1, 1, 1, 8, 1, 0, 0, 0), F_NORM};     // ALU producer, forwarded
    tbl[9] = '{mk(0, 0, 8, 1, 1, 1, 8, 0, 1, 0, 0), F_NORM};     // load without reg write

    do_reset(lu8);

    for (int i = 0; i < 10; i++) begin
      step(tbl[i].in);
      chk($sformatf("tbl[%0d] u0", i), int'(g_fl[0]), int'(tbl[i].exp));
    end

    // single and triple load-use bubbles
    do_reset(idle);
    cnt = 0;
    step(lu8);
    if (g_fl[1][0]) cnt++;
    step(bub8);
    chk("T1 u0 pc_write after bubble", int'(g_fl[0][5]), 1);
    if (g_fl[1][0]) cnt++;
    for (int i = 0; i < 4; i++) begin
      step(idle);
      if (g_fl[1][0]) cnt++;
    end
    chk("T1 u0 stall_cnt", g_sc[0], 1);
    chk("T2 u1 stall cycles", cnt, 3);
    chk("T2 u1 stall_cnt", g_sc[1], 3);
    chk("T2 u1 back to run", int'(g_fl[1]), int'(F_NORM));

    // branch in the 2nd stall cycle aborts the stall
    do_reset(idle);
    step(lu8);
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    chk("T4 u1 branch flags", int'(g_fl[1]), int'(F_BR));
    step(idle);
    chk("T4 u1 stall after branch", int'(g_fl[1][0]), 0);
    chk("T4 u1 stall_cnt", g_sc[1], 1);
    chk("T4 u1 flush_cnt", g_fc[1], 1);

    // jump during LSTALL is ignored and not counted
    do_reset(idle);
    step(lu8);
    step(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    chk("jump in lstall u1", int'(g_fl[1]), int'(F_STALL));
    step(idle);
    step(idle);
    chk("jump in lstall flush_cnt u1", g_fc[1], 0);

    // RAW stall without forwarding, held while producer sits in MEM
    do_reset(idle);
    for (int i = 0; i < 3; i++) begin
      step(mk(0, 0, 8, 0, 1, 0, 0, 0, 0, 8, 1));
      chk("T5 u2 raw stall", int'(g_fl[2][0]), 1);
      chk("T5 u1 no stall", int'(g_fl[1][0]), 0);
    end
    step(mk(0, 0, 8, 0, 1, 0, 0, 0, 0, 5, 1));
    chk("T5 u2 released", int'(g_fl[2][0]), 0);

    // counter saturation, then reset in the middle of a stall
    do_reset(idle);
    for (int i = 0; i < 21; i++) step(lu8);
    chk("T6 u1 stall_cnt saturated", g_sc[1], 15);
    chk("T6 u0 stall_cnt", g_sc[0], 21 - 1);
    do_reset(lu8);
    step(idle);
    chk("T6 u1 after reset", int'(g_fl[1]), int'(F_NORM));

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      in_t v;
      v = mk($urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0,
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
             5'($urandom_range(0, 3)), $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
             5'($urandom_range(0, 3)), $urandom_range(0, 1) == 1);
      if ($urandom_range(0, 99) == 0) do_reset(v);
      else step(v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
